cdc_addr_egress: RTL and testbench

// - Read-side consumer of the clock-crossing address FIFO: pops 49-bit address words, buffers up to 2, drives a valid/ready master port.
// - Word unpacks to {id[48:41], addr[40:9], len[8:5], size[4:2], burst[1:0]}.
// - Limits in-flight transactions (issued, awaiting rsp_done) to MAX_OUTSTANDING; sits in the FIFO read-clock domain.

---
 rtl/cdc_addr_egress_pkg.sv | 44 ++++
 rtl/cdc_addr_egress_if.sv | 30 +++
 rtl/cdc_addr_egress_skid_buf2.sv | 72 +++++++
 rtl/cdc_addr_egress.sv | 99 +++++++++
 tb/tb_cdc_addr_egress.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_addr_egress_pkg.sv
// Shared types for the address-FIFO egress stage: request field layout,
// buffer occupancy encoding and the FIFO-word unpack helper.
package cdc_addr_egress_pkg;

  localparam int REQ_ID_BITS    = 8;
  localparam int REQ_ADDR_BITS  = 32;
  localparam int REQ_LEN_BITS   = 4;
  localparam int REQ_SIZE_BITS  = 3;
  localparam int REQ_BURST_BITS = 2;
  localparam int REQ_DATA_BITS  = REQ_ID_BITS + REQ_ADDR_BITS + REQ_LEN_BITS
                                + REQ_SIZE_BITS + REQ_BURST_BITS;

  // Bit offsets of each field inside the FIFO word, LSB first.
  localparam int BURST_LSB = 0;
  localparam int SIZE_LSB  = BURST_LSB + REQ_BURST_BITS;
  localparam int LEN_LSB   = SIZE_LSB + REQ_SIZE_BITS;
  localparam int ADDR_LSB  = LEN_LSB + REQ_LEN_BITS;
  localparam int ID_LSB    = ADDR_LSB + REQ_ADDR_BITS;

  typedef struct packed {
    logic [REQ_ID_BITS-1:0]    id;
    logic [REQ_ADDR_BITS-1:0]  addr;
    logic [REQ_LEN_BITS-1:0]   len;
    logic [REQ_SIZE_BITS-1:0]  size;
    logic [REQ_BURST_BITS-1:0] burst;
  } addr_req_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  function automatic addr_req_t unpack_word(input logic [REQ_DATA_BITS-1:0] w);
    addr_req_t r;
    r.id    = w[ID_LSB    +: REQ_ID_BITS];
    r.addr  = w[ADDR_LSB  +: REQ_ADDR_BITS];
    r.len   = w[LEN_LSB   +: REQ_LEN_BITS];
    r.size  = w[SIZE_LSB  +: REQ_SIZE_BITS];
    r.burst = w[BURST_LSB +: REQ_BURST_BITS];
    return r;
  endfunction

endpackage

// File: rtl/cdc_addr_egress_if.sv
// Downstream address request channel: valid/ready plus unpacked request fields.
interface cdc_addr_egress_if
  import cdc_addr_egress_pkg::*;
#(
  parameter int ID_BITS    = REQ_ID_BITS,
  parameter int ADDR_BITS  = REQ_ADDR_BITS,
  parameter int LEN_BITS   = REQ_LEN_BITS,
  parameter int SIZE_BITS  = REQ_SIZE_BITS,
  parameter int BURST_BITS = REQ_BURST_BITS
) ();

  logic                  m_valid;
  logic                  m_ready;
  logic [ID_BITS-1:0]    m_id;
  logic [ADDR_BITS-1:0]  m_addr;
  logic [LEN_BITS-1:0]   m_len;
  logic [SIZE_BITS-1:0]  m_size;
  logic [BURST_BITS-1:0] m_burst;

  modport master (
    output m_valid, m_id, m_addr, m_len, m_size, m_burst,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_id, m_addr, m_len, m_size, m_burst,
    output m_ready
  );

endinterface

// File: rtl/cdc_addr_egress_skid_buf2.sv
// Two-entry valid/ready buffer with registered output; the head entry drives
// the output directly so downstream sees flop outputs only.
module cdc_addr_egress_skid_buf2
  import cdc_addr_egress_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid_i,
  output logic      in_ready_o,
  input  addr_req_t in_data_i,
  output logic      out_valid_o,
  input  logic      out_ready_i,
  output addr_req_t out_data_o,
  output occ_e      occ_o
);

  occ_e      occ_q;
  addr_req_t head_q;
  addr_req_t tail_q;
  logic      push;
  logic      pop;

  assign pop        = (occ_q != OCC_EMPTY) && out_ready_i;
  // A pop in the same cycle frees the slot the new word will land in.
  assign in_ready_o = (occ_q != OCC_TWO) || pop;
  assign push       = in_valid_i && in_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      // NOTE: both payload entries are reset as well, so the request fields
      // read as zero out of reset rather than as stale or unknown data.
      head_q <= '0;
      tail_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so head_q <= tail_q below picks
      // up the pre-edge tail, not a value written earlier in this block.
      unique case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            head_q <= in_data_i;
            occ_q  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          unique case ({push, pop})
            2'b10: begin
              tail_q <= in_data_i;
              occ_q  <= OCC_TWO;
            end
            2'b01: occ_q  <= OCC_EMPTY;
            2'b11: head_q <= in_data_i;
            default: ;
          endcase
        end
        OCC_TWO: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) tail_q <= in_data_i;
            else      occ_q  <= OCC_ONE;
          end
        end
        default: occ_q <= OCC_EMPTY;
      endcase
    end
  end

  assign out_valid_o = (occ_q != OCC_EMPTY);
  assign out_data_o  = head_q;
  assign occ_o       = occ_q;

endmodule

// File: rtl/cdc_addr_egress.sv
// Read-side consumer of the clock-crossing address FIFO: pops words under a
// credit limit, buffers two, issues them downstream and tracks completions.
module cdc_addr_egress
  import cdc_addr_egress_pkg::*;
#(
  parameter  int DATA_BITS       = REQ_DATA_BITS,
  parameter  int ID_BITS         = REQ_ID_BITS,
  parameter  int ADDR_BITS       = REQ_ADDR_BITS,
  parameter  int LEN_BITS        = REQ_LEN_BITS,
  parameter  int SIZE_BITS       = REQ_SIZE_BITS,
  parameter  int BURST_BITS      = REQ_BURST_BITS,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_not_empty_i,
  input  logic [DATA_BITS-1:0]     fifo_r_data_i,
  output logic                     fifo_rd_en_o,
  cdc_addr_egress_if.master        m_if,
  input  logic                     rsp_done_i,
  output logic [CNT_BITS-1:0]      outstanding_o,
  output logic                     err_underflow_o
);

  addr_req_t           in_data;
  addr_req_t           head;
  occ_e                occ;
  logic                in_valid;
  logic                in_ready;
  logic                out_valid;
  logic                pop;
  logic                credit_ok;
  logic [CNT_BITS:0]   in_flight;
  logic [CNT_BITS-1:0] outstanding_q;
  logic                err_underflow_q;

  assign in_data = unpack_word(fifo_r_data_i);
  assign pop     = out_valid && m_if.m_ready;

  // Buffered words count against the credit limit as well as issued ones; a
  // pop only moves a credit from the buffer into outstanding_q.
  assign in_flight = (CNT_BITS + 1)'(occ) + {1'b0, outstanding_q};
  assign credit_ok = in_flight < (CNT_BITS + 1)'(MAX_OUTSTANDING);

  // Gated by rst so no pop is requested while the FIFO is being reset too.
  assign in_valid     = fifo_not_empty_i && credit_ok && !rst;
  assign fifo_rd_en_o = in_valid && in_ready;

  cdc_addr_egress_skid_buf2 u_buf (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (m_if.m_ready),
    .out_data_o  (head),
    .occ_o       (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q   <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      unique case ({pop, rsp_done_i})
        2'b10: outstanding_q <= outstanding_q + CNT_BITS'(1);
        2'b01: begin
          if (outstanding_q == '0) err_underflow_q <= 1'b1;
          else                     outstanding_q   <= outstanding_q - CNT_BITS'(1);
        end
        // Pop with completion nets to zero, including at a count of zero.
        default: ;
      endcase
    end
  end

  assign m_if.m_valid    = out_valid;
  assign m_if.m_id       = ID_BITS'(head.id);
  assign m_if.m_addr     = ADDR_BITS'(head.addr);
  assign m_if.m_len      = LEN_BITS'(head.len);
  assign m_if.m_size     = SIZE_BITS'(head.size);
  assign m_if.m_burst    = BURST_BITS'(head.burst);
  assign outstanding_o   = outstanding_q;
  assign err_underflow_o = err_underflow_q;

`ifndef SYNTHESIS
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    in_flight <= (CNT_BITS + 1)'(MAX_OUTSTANDING));

  a_rd_needs_data: assert property (@(posedge clk) disable iff (rst)
    fifo_rd_en_o |-> fifo_not_empty_i);

  a_hold_stall: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !m_if.m_ready) |=> (out_valid && $stable(head)));
`endif

endmodule

// File: tb/tb_cdc_addr_egress.sv
// Self-checking bench for cdc_addr_egress: a queue-based FIFO/scoreboard model,
// a table of directed cycles, hand-written corner sequences and a random run.
module tb_cdc_addr_egress;
  import cdc_addr_egress_pkg::*;

  localparam int MAXO  = 4;
  localparam int CNT_W = $clog2(MAXO + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_not_empty;
  logic [48:0]       fifo_r_data;
  logic              fifo_rd_en;
  logic              rsp_done;
  logic [CNT_W-1:0]  outstanding;
  logic              err_underflow;

  cdc_addr_egress_if m_if ();

  cdc_addr_egress #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_not_empty_i (fifo_not_empty),
    .fifo_r_data_i    (fifo_r_data),
    .fifo_rd_en_o     (fifo_rd_en),
    .m_if             (m_if),
    .rsp_done_i       (rsp_done),
    .outstanding_o    (outstanding),
    .err_underflow_o  (err_underflow)
  );

  always #5 clk = ~clk;

  // Reference model state: FIFO contents, words held between pop-from-FIFO
  // and downstream acceptance, issued words, in-flight count, sticky error.
  logic [48:0] fifo_q[$];
  logic [48:0] sb[$];
  logic [48:0] popped[$];
  int          exp_out;
  logic        exp_err;
  int          n_issued;
  int          n_checks;
  int          n_errs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [48:0] m_word();
    return {m_if.m_id, m_if.m_addr, m_if.m_len, m_if.m_size, m_if.m_burst};
  endfunction

  function automatic logic [48:0] rand_word();
    return {17'($urandom()), $urandom()};
  endfunction

  task automatic drive_fifo();
    if (fifo_q.size() != 0) begin
      fifo_not_empty = 1'b1;
      fifo_r_data    = fifo_q[0];
    end else begin
      fifo_not_empty = 1'b0;
      fifo_r_data    = rand_word();
    end
  endtask

  // One clock: compare DUT against the model at negedge, advance the model
  // just after posedge. Inputs must already be set.
  task automatic tick(output logic rd_seen);
    logic exp_pop;
    logic exp_rd;
    logic rsp;
    @(negedge clk);
    exp_pop = (sb.size() != 0) && m_if.m_ready;
    exp_rd  = (fifo_q.size() != 0) && (sb.size() < 2 || exp_pop)
              && (sb.size() + exp_out < MAXO);
    rsp     = rsp_done;
    rd_seen = fifo_rd_en;
    check("m_valid", 64'(m_if.m_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) check("m_word", 64'(m_word()), 64'(sb[0]));
    check("fifo_rd_en", 64'(fifo_rd_en), 64'(exp_rd));
    check("outstanding", 64'(outstanding), 64'(exp_out));
    check("err_underflow", 64'(err_underflow), 64'(exp_err));
    @(posedge clk);
    #1;
    if (exp_pop) begin
      popped.push_back(sb.pop_front());
      n_issued++;
    end
    if (exp_pop && !rsp) exp_out++;
    else if (!exp_pop && rsp) begin
      if (exp_out == 0) exp_err = 1'b1;
      else              exp_out--;
    end
    if (exp_rd) sb.push_back(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    m_if.m_ready = 1'b0;
    rsp_done    = 1'b0;
    #1;
    check("rst_m_valid", 64'(m_if.m_valid), 64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_err", 64'(err_underflow), 64'(0));
    check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
    fifo_q.delete();
    sb.delete();
    popped.delete();
    exp_out = 0;
    exp_err = 1'b0;
    drive_fifo();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        load;
    logic [48:0] word;
    logic        mr;
    logic        rsp;
    logic        exp_rd;
    logic        exp_mv;
    int          exp_out;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rd;
    int          rd_cnt;
    int          cycles;
    logic [48:0] w3[3];

    n_checks = 0;
    n_errs   = 0;
    n_issued = 0;

    // Cycle-by-cycle table: optional FIFO load, m_ready, rsp_done, then the
    // fifo_rd_en seen before the edge and the state after it.
    vecs[0]  = '{1'b1, 49'h0_0A12_3456_78, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[1]  = '{1'b1, 49'h1_2345_6789_ABCD, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0};
    vecs[2]  = '{1'b0, 49'h0,               1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[3]  = '{1'b0, 49'h0,               1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[4]  = '{1'b0, 49'h0,               1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1};
    vecs[5]  = '{1'b1, 49'h1_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1};
    vecs[6]  = '{1'b1, 49'h0_AAAA_5555_AAAA, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b1};
    vecs[7]  = '{1'b1, 49'h1_5555_AAAA_5555, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1};
    vecs[8]  = '{1'b0, 49'h0,               1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1};
    vecs[9]  = '{1'b0, 49'h0,               1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1};
    vecs[10] = '{1'b0, 49'h0,               1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1};
    vecs[11] = '{1'b0, 49'h0,               1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1};

    fifo_not_empty = 1'b0;
    fifo_r_data    = '0;
    do_reset();
    check("rst_m_id", 64'(m_if.m_id), 64'(0));
    check("rst_m_addr", 64'(m_if.m_addr), 64'(0));
    check("rst_m_len_size_burst", 64'({m_if.m_len, m_if.m_size, m_if.m_burst}), 64'(0));

    foreach (vecs[i]) begin
      if (vecs[i].load) fifo_q.push_back(vecs[i].word);
      drive_fifo();
      m_if.m_ready = vecs[i].mr;
      rsp_done     = vecs[i].rsp;
      tick(rd);
      check($sformatf("vec%0d_rd_en", i), 64'(rd), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d_m_valid", i), 64'(m_if.m_valid), 64'(vecs[i].exp_mv));
      check($sformatf("vec%0d_outstanding", i), 64'(outstanding), 64'(vecs[i].exp_out));
      check($sformatf("vec%0d_err", i), 64'(err_underflow), 64'(vecs[i].exp_err));
      if (vecs[i].exp_mv)
        check($sformatf("vec%0d_head", i), 64'(m_word()), 64'(vecs[i].word));
    end
    rsp_done = 1'b0;
    m_if.m_ready = 1'b0;
    tick(rd);
    check("err_sticky", 64'(err_underflow), 64'(1));

    // Single word: fields follow id[48:41] addr[40:9] len[8:5] size[4:2] burst[1:0].
    do_reset();
    fifo_q.push_back(49'h0_0A12_3456_78);
    drive_fifo();
    m_if.m_ready = 1'b1;
    tick(rd);
    check("single_rd_en", 64'(rd), 64'(1));
    check("single_m_valid", 64'(m_if.m_valid), 64'(1));
    check("single_id", 64'(m_if.m_id), 64'(8'h00));
    check("single_addr", 64'(m_if.m_addr), 64'(32'h0509_1A2B));
    check("single_len", 64'(m_if.m_len), 64'(4'h3));
    check("single_size", 64'(m_if.m_size), 64'(3'h6));
    check("single_burst", 64'(m_if.m_burst), 64'(2'h0));
    tick(rd);
    check("single_outstanding", 64'(outstanding), 64'(1));
    check("single_m_valid_after", 64'(m_if.m_valid), 64'(0));

    // Six queued words with no completions: credit stops issue at MAXO.
    do_reset();
    for (int i = 0; i < 6; i++) fifo_q.push_back(rand_word());
    drive_fifo();
    m_if.m_ready = 1'b1;
    rd_cnt = 0;
    repeat (8) begin
      tick(rd);
      rd_cnt += int'(rd);
    end
    check("credit_pops", 64'(rd_cnt), 64'(MAXO));
    check("credit_outstanding", 64'(outstanding), 64'(MAXO));
    check("credit_rd_en_idle", 64'(fifo_rd_en), 64'(0));
    rsp_done = 1'b1;
    rd_cnt = 0;
    tick(rd);
    rd_cnt += int'(rd);
    rsp_done = 1'b0;
    repeat (5) begin
      tick(rd);
      rd_cnt += int'(rd);
    end
    check("credit_one_more", 64'(rd_cnt), 64'(1));
    check("credit_outstanding_again", 64'(outstanding), 64'(MAXO));
    check("credit_rd_en_idle_again", 64'(fifo_rd_en), 64'(0));

    // Stall with three words queued, then drain in order, one per cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w3[i] = rand_word();
      fifo_q.push_back(w3[i]);
    end
    drive_fifo();
    m_if.m_ready = 1'b0;
    repeat (10) tick(rd);
    check("stall_rd_en", 64'(fifo_rd_en), 64'(0));
    check("stall_m_valid", 64'(m_if.m_valid), 64'(1));
    check("stall_head", 64'(m_word()), 64'(w3[0]));
    m_if.m_ready = 1'b1;
    popped.delete();
    repeat (3) tick(rd);
    check("drain_count", 64'(popped.size()), 64'(3));
    for (int i = 0; i < 3; i++)
      if (i < popped.size()) check($sformatf("drain_order%0d", i), 64'(popped[i]), 64'(w3[i]));
    check("drain_m_valid", 64'(m_if.m_valid), 64'(0));

    // Reset while the buffer is full and transactions are in flight.
    do_reset();
    for (int i = 0; i < 5; i++) fifo_q.push_back(rand_word());
    drive_fifo();
    m_if.m_ready = 1'b1;
    cycles = 0;
    while (exp_out < 2 && cycles < 20) begin
      tick(rd);
      cycles++;
    end
    check("rstmid_reach_out2", 64'(exp_out), 64'(2));
    m_if.m_ready = 1'b0;
    repeat (4) tick(rd);
    check("rstmid_pre_out", 64'(outstanding), 64'(2));
    check("rstmid_pre_m_valid", 64'(m_if.m_valid), 64'(1));
    check("rstmid_pre_buffered", 64'(sb.size()), 64'(2));
    rst = 1'b1;
    #1;
    check("rstmid_m_valid", 64'(m_if.m_valid), 64'(0));
    check("rstmid_outstanding", 64'(outstanding), 64'(0));
    check("rstmid_rd_en", 64'(fifo_rd_en), 64'(0));
    @(posedge clk);
    #1;
    check("rstmid_edge_m_valid", 64'(m_if.m_valid), 64'(0));
    check("rstmid_edge_rd_en", 64'(fifo_rd_en), 64'(0));

    // Random traffic against the scoreboard.
    do_reset();
    n_issued = 0;
    cycles   = 0;
    while (n_issued < 10000 && cycles < 60000) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 3) != 0) fifo_q.push_back(rand_word());
      drive_fifo();
      m_if.m_ready = ($urandom_range(0, 3) != 0);
      rsp_done     = (exp_out > 0) && ($urandom_range(0, 3) != 0);
      tick(rd);
      cycles++;
    end
    check("rand_issued", 64'(n_issued), 64'(10000));
    check("rand_no_underflow", 64'(err_underflow), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
